// File: rtl/mine_pkg.sv
// Shared types for the minesweeper controller: game states and the move
// direction encoding understood by the board cells.
package mine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLACE = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } game_state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

endpackage

// File: rtl/mine_lfsr.sv
// 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1) with a synchronous
// active-low reset to SEED; exposes only the low OUT_W bits of its state.
module mine_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             resetn_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] value_o
);

    localparam logic [15:0] TAP_MASK = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAP_MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game controller: owns the bomb/reveal/cursor grids, places bombs
// from a free-running LFSR and drives the combinational board's move/dir inputs.
module mine_game_ctrl
    import mine_pkg::*;
#(
    parameter int          GRID_SIZE = 3,
    parameter int          NUM_BOMBS = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           btn_start,
    input  logic                           btn_move,
    input  logic [1:0]                     btn_dir,
    input  logic                           btn_reveal,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] next_cursor_grid,
    output logic [GRID_SIZE*GRID_SIZE-1:0] bomb_grid,
    output logic [GRID_SIZE*GRID_SIZE-1:0] reveal_grid,
    output logic [GRID_SIZE*GRID_SIZE-1:0] cursor_grid,
    output logic                           move,
    output logic [1:0]                     dir,
    output logic [2:0]                     game_state
);

    localparam int CELLS  = GRID_SIZE * GRID_SIZE;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int RC_W   = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int CENTRE = CELLS / 2;
    localparam logic [RC_W-1:0]  CENTRE_ROW    = RC_W'(CENTRE / GRID_SIZE);
    localparam logic [RC_W-1:0]  CENTRE_COL    = RC_W'(CENTRE % GRID_SIZE);
    localparam logic [CELLS-1:0] CENTRE_ONEHOT = CELLS'(1) << CENTRE;

    game_state_t      state_q, state_d;
    logic [CELLS-1:0] bomb_q, bomb_d;
    logic [CELLS-1:0] reveal_q, reveal_d;
    logic [CELLS-1:0] cursor_q, cursor_d;
    logic             move_q, move_d;
    logic [1:0]       dir_q, dir_d;
    logic [RC_W-1:0]  row_q, row_d;
    logic [RC_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0] placed_q, placed_d;
    logic [CNT_W-1:0] revealed_q, revealed_d;
    logic             start_btn_q, move_btn_q, reveal_btn_q;

    logic             start_req, move_req, reveal_req;
    logic [RC_W-1:0]  row_eff, col_eff;
    logic [IDX_W-1:0] eff_idx;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic             move_ok;

    mine_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (IDX_W)
    ) u_lfsr (
        .clk      (clk),
        .resetn_i (resetn),
        .en_i     (1'b1),
        .value_o  (cand)
    );

    assign start_req  = btn_start  & ~start_btn_q;
    assign move_req   = btn_move   & ~move_btn_q;
    assign reveal_req = btn_reveal & ~reveal_btn_q;

    // Cursor position as it will be after any in-flight move lands this cycle,
    // so a reveal or move sampled now always acts on the up-to-date cell.
    always_comb begin
        row_eff = row_q;
        col_eff = col_q;
        if (move_q) begin
            case (dir_q)
                DIR_RIGHT: col_eff = col_q - 1'b1;
                DIR_UP:    row_eff = row_q + 1'b1;
                DIR_LEFT:  col_eff = col_q + 1'b1;
                default:   row_eff = row_q - 1'b1;
            endcase
        end
    end

    assign eff_idx = IDX_W'(int'(row_eff) * GRID_SIZE + int'(col_eff));

    always_comb begin
        move_ok = 1'b0;
        case (btn_dir)
            DIR_RIGHT: move_ok = (col_eff != '0);
            DIR_UP:    move_ok = (row_eff != RC_W'(GRID_SIZE - 1));
            DIR_LEFT:  move_ok = (col_eff != RC_W'(GRID_SIZE - 1));
            default:   move_ok = (row_eff != '0);
        endcase
    end

    assign cand_ok = (int'(cand) < CELLS) && !bomb_q[cand] && (int'(cand) != CENTRE);

    always_comb begin
        state_d    = state_q;
        bomb_d     = bomb_q;
        reveal_d   = reveal_q;
        cursor_d   = move_q ? next_cursor_grid : cursor_q;
        move_d     = 1'b0;
        dir_d      = dir_q;
        row_d      = row_eff;
        col_d      = col_eff;
        placed_d   = placed_q;
        revealed_d = revealed_q;

        if (start_req) begin
            state_d    = PLACE;
            bomb_d     = '0;
            reveal_d   = '0;
            cursor_d   = CENTRE_ONEHOT;
            row_d      = CENTRE_ROW;
            col_d      = CENTRE_COL;
            placed_d   = '0;
            revealed_d = '0;
        end else begin
            case (state_q)
                PLACE: begin
                    if (cand_ok) begin
                        bomb_d[cand] = 1'b1;
                        placed_d     = placed_q + CNT_W'(1);
                        if (int'(placed_q) + 1 == NUM_BOMBS) begin
                            state_d = PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (reveal_req) begin
                        if (!reveal_q[eff_idx]) begin
                            if (bomb_q[eff_idx]) begin
                                reveal_d = '1;
                                state_d  = LOSE;
                            end else begin
                                reveal_d[eff_idx] = 1'b1;
                                revealed_d        = revealed_q + CNT_W'(1);
                                if (int'(revealed_q) + 1 == CELLS - NUM_BOMBS) begin
                                    state_d = WIN;
                                end
                            end
                        end
                    end else if (move_req && move_ok) begin
                        move_d = 1'b1;
                        dir_d  = btn_dir;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bomb_q       <= '0;
            reveal_q     <= '0;
            cursor_q     <= CENTRE_ONEHOT;
            move_q       <= 1'b0;
            dir_q        <= DIR_RIGHT;
            row_q        <= CENTRE_ROW;
            col_q        <= CENTRE_COL;
            placed_q     <= '0;
            revealed_q   <= '0;
            start_btn_q  <= 1'b0;
            move_btn_q   <= 1'b0;
            reveal_btn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bomb_q       <= bomb_d;
            reveal_q     <= reveal_d;
            cursor_q     <= cursor_d;
            move_q       <= move_d;
            dir_q        <= dir_d;
            row_q        <= row_d;
            col_q        <= col_d;
            placed_q     <= placed_d;
            revealed_q   <= revealed_d;
            start_btn_q  <= btn_start;
            move_btn_q   <= btn_move;
            reveal_btn_q <= btn_reveal;
        end
    end

    assign bomb_grid   = bomb_q;
    assign reveal_grid = reveal_q;
    assign cursor_grid = cursor_q;
    assign move        = move_q;
    assign dir         = dir_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Directed-plus-random bench for mine_game_ctrl on a 3x3 board with 2 bombs,
// checked against a cell/row/column game model and an LFSR sequence model.
module tb_mine_game_ctrl;

    localparam int          N     = 3;
    localparam int          CELLS = N * N;
    localparam int          NB    = 2;
    localparam int          C     = CELLS / 2;
    localparam int          IDX_W = $clog2(CELLS);
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             btn_start, btn_move, btn_reveal;
    logic [1:0]       btn_dir;
    logic [CELLS-1:0] next_cursor_grid;
    logic [CELLS-1:0] bomb_grid, reveal_grid, cursor_grid;
    logic             move;
    logic [1:0]       dir;
    logic [2:0]       game_state;

    int checks   = 0;
    int failures = 0;

    logic [15:0]      lfsr_m;
    int               m_state, m_row, m_col, m_revealed;
    logic [CELLS-1:0] m_bomb, m_rev;

    mine_game_ctrl #(
        .GRID_SIZE (N),
        .NUM_BOMBS (NB),
        .LFSR_SEED (SEED)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .btn_start        (btn_start),
        .btn_move         (btn_move),
        .btn_dir          (btn_dir),
        .btn_reveal       (btn_reveal),
        .next_cursor_grid (next_cursor_grid),
        .bomb_grid        (bomb_grid),
        .reveal_grid      (reveal_grid),
        .cursor_grid      (cursor_grid),
        .move             (move),
        .dir              (dir),
        .game_state       (game_state)
    );

    always #5 clk = ~clk;

    // Combinational board: shift the one-hot cursor one cell in direction dir.
    always_comb begin
        next_cursor_grid = cursor_grid;
        case (dir)
            2'b00:   next_cursor_grid = cursor_grid >> 1;
            2'b01:   next_cursor_grid = cursor_grid << N;
            2'b10:   next_cursor_grid = cursor_grid << 1;
            default: next_cursor_grid = cursor_grid >> N;
        endcase
    end

    // Placement LFSR sequence: free-running Galois x^16+x^14+x^13+x^11+1.
    always @(posedge clk) begin
        if (!resetn) lfsr_m <= SEED;
        else         lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CELLS-1:0] cursor_exp();
        logic [CELLS-1:0] one;
        one = 1;
        return one << (m_row * N + m_col);
    endfunction

    function automatic bit legal_dir(input int d);
        case (d)
            0:       return m_col != 0;
            1:       return m_row != N - 1;
            2:       return m_col != N - 1;
            default: return m_row != 0;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},  16'(game_state),  16'd0);
        chk({tag, "_bomb"},   16'(bomb_grid),   16'h000);
        chk({tag, "_reveal"}, 16'(reveal_grid), 16'h000);
        chk({tag, "_cursor"}, 16'(cursor_grid), 16'h010);
        chk({tag, "_move"},   16'(move),        16'h0);
        chk({tag, "_dir"},    16'(dir),         16'h0);
    endtask

    task automatic press_move(input int d);
        bit ok;
        ok = (m_state == 2) && legal_dir(d);
        btn_move = 1'b1;
        btn_dir  = 2'(d);
        tick();
        chk("move_strobe", 16'(move), 16'(ok));
        if (ok) chk("move_dir", 16'(dir), 16'(d));
        btn_move = 1'b0;
        if (ok) begin
            case (d)
                0:       m_col--;
                1:       m_row++;
                2:       m_col++;
                default: m_row--;
            endcase
        end
        tick();
        chk("move_single", 16'(move), 16'h0);
        chk("move_cursor", 16'(cursor_grid), 16'(cursor_exp()));
        $display("move dir=%0d legal=%0d cursor=%03h", d, ok, cursor_grid);
    endtask

    task automatic press_reveal(input bit with_move, input int d);
        int idx;
        idx = m_row * N + m_col;
        btn_reveal = 1'b1;
        btn_move   = with_move;
        btn_dir    = 2'(d);
        tick();
        if (m_state == 2 && !m_rev[idx]) begin
            if (m_bomb[idx]) begin
                m_rev   = '1;
                m_state = 4;
            end else begin
                m_rev[idx] = 1'b1;
                m_revealed++;
                if (m_revealed == CELLS - NB) m_state = 3;
            end
        end
        chk("reveal_grid",  16'(reveal_grid), 16'(m_rev));
        chk("reveal_state", 16'(game_state),  16'(m_state));
        chk("reveal_nomove", 16'(move), 16'h0);
        btn_reveal = 1'b0;
        btn_move   = 1'b0;
        tick();
        chk("reveal_nomove2", 16'(move), 16'h0);
        chk("reveal_cursor", 16'(cursor_grid), 16'(cursor_exp()));
        $display("reveal cell=%0d with_move=%0d reveal=%03h state=%0d", idx, with_move, reveal_grid, game_state);
    endtask

    task automatic press_start();
        int placed;
        int k;
        btn_start = 1'b1;
        tick();
        btn_start  = 1'b0;
        m_state    = 1;
        m_bomb     = '0;
        m_rev      = '0;
        m_row      = C / N;
        m_col      = C % N;
        m_revealed = 0;
        chk("start_state",  16'(game_state),  16'd1);
        chk("start_reveal", 16'(reveal_grid), 16'h000);
        chk("start_cursor", 16'(cursor_grid), 16'(cursor_exp()));
        placed = 0;
        for (int guard = 0; guard < 1000 && placed < NB; guard++) begin
            k = int'(lfsr_m[IDX_W-1:0]);
            if (k < CELLS && !m_bomb[k] && k != C) begin
                m_bomb[k] = 1'b1;
                placed++;
            end
            tick();
            if (placed < NB) chk("place_busy", 16'(game_state), 16'd1);
        end
        m_state = 2;
        chk("place_state",   16'(game_state), 16'd2);
        chk("place_bombs",   16'(bomb_grid),  16'(m_bomb));
        chk("place_count",   16'($countones(bomb_grid)), 16'(NB));
        chk("place_centre",  16'(bomb_grid[C]), 16'h0);
        chk("place_cursor",  16'(cursor_grid), 16'h010);
        $display("start bombs=%03h state=%0d", bomb_grid, game_state);
    endtask

    task automatic goto_cell(input int target);
        for (int s = 0; s < 2 * N && (m_row * N + m_col) != target; s++) begin
            if (target / N > m_row)      press_move(1);
            else if (target / N < m_row) press_move(3);
            else if (target % N > m_col) press_move(2);
            else                         press_move(0);
        end
        chk("goto_cursor", 16'(cursor_grid), 16'(cursor_exp()));
    endtask

    int safe_cells[$];
    int tmp, pick, bomb_cell, pd;

    initial begin
        resetn     = 1'b0;
        btn_start  = 1'b0;
        btn_move   = 1'b0;
        btn_reveal = 1'b0;
        btn_dir    = 2'b00;
        m_state    = 0;
        m_row      = C / N;
        m_col      = C % N;
        m_bomb     = '0;
        m_rev      = '0;
        m_revealed = 0;
        repeat (3) tick();
        check_reset_values("reset");
        resetn = 1'b1;
        tick();

        // Requests in IDLE have no effect.
        press_move(1);
        press_reveal(1'b0, 0);
        chk("idle_state", 16'(game_state), 16'd0);

        press_start();

        // Held move button from the centre: one strobe, cursor lands a row up.
        btn_move = 1'b1;
        btn_dir  = 2'b01;
        tick();
        chk("held_move",   16'(move), 16'h1);
        chk("held_dir",    16'(dir),  16'h1);
        tick();
        chk("held_single", 16'(move), 16'h0);
        chk("held_cursor", 16'(cursor_grid), 16'h080);
        tick();
        chk("held_quiet",  16'(move), 16'h0);
        btn_move = 1'b0;
        tick();
        m_row = m_row + 1;
        press_move(1);

        for (int r = 0; r < 24; r++) press_move(int'($urandom_range(0, 3)));

        goto_cell(0);
        press_move(0);
        press_move(3);
        chk("corner_cursor", 16'(cursor_grid), 16'h001);

        // Reveal every safe cell in random order; the first reveal races a move.
        for (int c = 0; c < CELLS; c++) if (!m_bomb[c]) safe_cells.push_back(c);
        for (int s = safe_cells.size() - 1; s > 0; s--) begin
            pick = int'($urandom_range(0, s));
            tmp = safe_cells[s];
            safe_cells[s] = safe_cells[pick];
            safe_cells[pick] = tmp;
        end
        for (int s = 0; s < safe_cells.size(); s++) begin
            goto_cell(safe_cells[s]);
            if (s == 0) begin
                pd = 0;
                while (!legal_dir(pd)) pd++;
                press_reveal(1'b1, pd);
            end else begin
                press_reveal(1'b0, 0);
            end
            if (s == 2) press_reveal(1'b0, 0);
        end
        chk("win_state",  16'(game_state),  16'd3);
        chk("win_reveal", 16'(reveal_grid), 16'(m_rev));
        press_move(1);
        press_move(3);
        press_reveal(1'b0, 0);

        // Second game: walk onto a bomb and reveal it.
        press_start();
        bomb_cell = 0;
        while (!m_bomb[bomb_cell]) bomb_cell++;
        goto_cell(bomb_cell);
        press_reveal(1'b0, 0);
        chk("lose_reveal", 16'(reveal_grid), 16'h1FF);
        chk("lose_state",  16'(game_state),  16'd4);
        press_move(0);
        press_move(2);
        press_reveal(1'b0, 0);
        chk("lose_frozen", 16'(game_state), 16'd4);

        // Reset while bombs are being placed.
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        chk("midplace_state", 16'(game_state), 16'd1);
        resetn = 1'b0;
        tick();
        check_reset_values("midplace_reset");
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mine_game_ctrl.md
# mine_game_ctrl

Sequential game controller sitting directly upstream of the combinational minesweeper board array. It owns the registered `bomb_grid`, `reveal_grid` and `cursor_grid` vectors and drives the board's `move`/`dir` inputs. It closes the cursor loop by capturing the board's `next_cursor_grid` result. It also places bombs pseudo-randomly and tracks win/lose state from player button pulses.

## Interface
- `GRID_SIZE`, default 3: board edge length; N = GRID_SIZE, cells = N*N.
- `NUM_BOMBS`, default 2: bombs placed per game; must satisfy 1 ≤ NUM_BOMBS ≤ N*N-2.
- `LFSR_SEED`, default 16'hACE1: nonzero reset value of the placement LFSR.

- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-low reset.
- `btn_start` in 1: level; a rising edge starts a new game.
- `btn_move` in 1: level; a rising edge requests a cursor move.
- `btn_dir` in 2: direction sampled with the `btn_move` edge. 00 right (toward lower column index j), 01 up, 10 left, 11 down.
- `btn_reveal` in 1: level; a rising edge reveals the cursor cell.
- `next_cursor_grid` in N*N: combinational cursor result from the board.
- `bomb_grid` out N*N: registered bomb map.
- `reveal_grid` out N*N: registered revealed map.
- `cursor_grid` out N*N: registered one-hot cursor.
- `move` out 1: one-cycle move strobe to the board.
- `dir` out 2: direction to the board; valid while `move`=1.
- `game_state` out 3: 0 IDLE, 1 PLACE, 2 PLAY, 3 WIN, 4 LOSE.

## Operation
- **Cell indexing:** index x = i*N + j. Row i=0 is the bottom row; column j=0 is the right column. The centre cell C = (N*N)/2.
- **Reset values:** `bomb_grid`=0, `reveal_grid`=0, `cursor_grid`=one-hot C, `move`=0, `dir`=00, `game_state`=IDLE, LFSR=`LFSR_SEED`, all counters 0.
- **Edge detection:** each button has a registered previous-value flop. A request is `btn & ~btn_q`.
- **IDLE:** a start request clears the bomb and reveal grids, sets the cursor to C and enters PLACE.
- **PLACE:**
  - Each cycle the LFSR advances. Candidate k = low ceil(log2(N*N)) LFSR bits.
  - Reject the candidate if k ≥ N*N, `bomb_grid[k]`=1, or k=C (the start cell is always safe).
  - Otherwise set `bomb_grid[k]` and increment the placed count.
  - Once the count reaches NUM_BOMBS, enter PLAY.
  - Move and reveal requests are ignored in PLACE.
- **PLAY, move:**
  - A move request is legal unless it would leave the board: 00 with j=0, 01 with i=N-1, 10 with j=N-1, 11 with i=0.
  - An illegal request is dropped silently.
  - A legal request registers `move`=1 and `dir`=`btn_dir` for exactly one cycle.
  - During that cycle the controller loads `cursor_grid` ← `next_cursor_grid` and updates its internal cursor index register to match.
- **PLAY, reveal:**
  - If the cursor cell is already revealed, the request is a no-op.
  - If the cursor cell is a bomb, set `reveal_grid` to all ones and enter LOSE.
  - Otherwise set the cell's reveal bit and increment the revealed count. When the count reaches N*N-NUM_BOMBS, enter WIN.
- **Simultaneous requests:** reveal takes priority over move in the same cycle; the move is dropped. A start request has priority over everything, in every state.
- **WIN/LOSE:** the grids are frozen and only a start request is honoured.
- **Reset mid-operation:** reset in any state, including mid-PLACE or with `move` high, returns all outputs to their reset values on the next edge.

## Timing
- A button edge sampled at edge t produces its effect at edge t+1:
  - for a move, `move`=1 during cycle t+1;
  - for a reveal, `reveal_grid` and `game_state` update at edge t+1.
- The board is combinational, so `cursor_grid` updates at the end of the `move` cycle, visible 2 edges after the button edge.
- A held button yields exactly one request.
- `move` is never high on two consecutive cycles.
- PLACE latency is ≥ NUM_BOMBS cycles and unbounded only by LFSR rejections.
- The LFSR is 16-bit maximal, taps 16,14,13,11, and free-runs in every state so seeds differ between games.

## Structure
- Shared package `mine_pkg`:
  - `game_state_t` enum (IDLE..LOSE);
  - direction constants `DIR_RIGHT`=2'b00, `DIR_UP`=2'b01, `DIR_LEFT`=2'b10, `DIR_DOWN`=2'b11. These are the encoding the board cells use.
- One sub-module: `mine_lfsr`, a 16-bit Galois LFSR with seed parameter, enable and synchronous active-low reset.

## Test plan
- **Reset and placement:** reset with N=3, NUM_BOMBS=2, then pulse start. `game_state` goes 1 then 2; `bomb_grid` has popcount 2 and bit 4 is 0; `cursor_grid`=9'h010.
- **Legal move:** in PLAY, btn_move with dir=01 from cursor 4. `move`=1 and `dir`=01 for one cycle, then `cursor_grid`=9'h080. Repeating dir=01 produces no `move` strobe.
- **Illegal move at the edge:** cursor at index 0, dir=00 and then 11. `move` stays 0 and `cursor_grid` stays 9'h001.
- **Reveal a bomb:** force bombs at {0,1} via seed or backdoor, move the cursor to 1, reveal. `reveal_grid`=9'h1FF and `game_state`=4. Later move and reveal requests are ignored.
- **Win:** reveal all 7 safe cells, including revealing one cell twice. `game_state`=3 exactly after the 7th distinct reveal.
- **Priority and reset:** assert btn_move and btn_reveal on the same edge; only the reveal occurs. Assert `resetn`=0 mid-PLACE; next edge gives IDLE, grids 0, cursor 9'h010.
